// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : interval_timer_ctrl
// Brief    : Programmable interval timer with one-shot/periodic modes, pause,
//            resume and stop control; emits tick, done and err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module interval_timer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] period,
  input  logic             periodic,
  output logic             busy,
  output logic             paused,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             done,
  output logic [WIDTH-1:0] periods,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_periods;
  logic [WIDTH-1:0] r_period_q;
  logic             r_mode_q;
  logic             r_busy;
  logic             r_paused;
  logic             r_tick;
  logic             r_done;
  logic             r_err;

  state_t           w_nxt_state;
  logic [WIDTH-1:0] w_nxt_count;
  logic [WIDTH-1:0] w_nxt_periods;
  logic [WIDTH-1:0] w_nxt_period_q;
  logic             w_nxt_mode_q;
  logic             w_nxt_tick;
  logic             w_nxt_done;
  logic             w_nxt_err;
  logic             w_last;

  assign w_last = (r_count == (r_period_q - c_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_periods  <= '0;
      r_period_q <= '0;
      r_mode_q   <= 1'b0;
      r_busy     <= 1'b0;
      r_paused   <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_count    <= w_nxt_count;
      r_periods  <= w_nxt_periods;
      r_period_q <= w_nxt_period_q;
      r_mode_q   <= w_nxt_mode_q;
      r_busy     <= (w_nxt_state != S_IDLE);
      r_paused   <= (w_nxt_state == S_PAUSED);
      r_tick     <= w_nxt_tick;
      r_done     <= w_nxt_done;
      r_err      <= w_nxt_err;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_count    = r_count;
    w_nxt_periods  = r_periods;
    w_nxt_period_q = r_period_q;
    w_nxt_mode_q   = r_mode_q;
    w_nxt_tick     = 1'b0;
    w_nxt_done     = 1'b0;
    w_nxt_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (period != '0) begin
            w_nxt_period_q = period;
            w_nxt_mode_q   = periodic;
            w_nxt_count    = '0;
            w_nxt_periods  = '0;
            w_nxt_state    = S_RUN;
          end else begin
            w_nxt_err = 1'b1;
          end
        end
      end
      S_RUN, S_PAUSED: begin
        // stop beats pause, pause beats counting; resume edge itself holds
        if (stop) begin
          w_nxt_state = S_IDLE;
          w_nxt_count = '0;
        end else if (pause) begin
          w_nxt_state = S_PAUSED;
        end else if (r_state == S_PAUSED) begin
          w_nxt_state = S_RUN;
        end else if (w_last) begin
          w_nxt_count   = '0;
          w_nxt_tick    = 1'b1;
          w_nxt_periods = r_periods + c_ONE;
          if (!r_mode_q) begin
            w_nxt_state = S_IDLE;
            w_nxt_done  = 1'b1;
          end
        end else begin
          w_nxt_count = r_count + c_ONE;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_count = '0;
      end
    endcase
  end

  assign busy    = r_busy;
  assign paused  = r_paused;
  assign count   = r_count;
  assign tick    = r_tick;
  assign done    = r_done;
  assign periods = r_periods;
  assign err     = r_err;

endmodule
`default_nettype wire
